// File: rtl/vad_pkg.sv
// Shared encodings for the VAD decision path: class codes from compare and the
// smoother state machine encoding.
package vad_pkg;

  localparam logic [1:0] RES_NONE      = 2'b00;
  localparam logic [1:0] RES_NONSPEECH = 2'b01;
  localparam logic [1:0] RES_SPEECH    = 2'b10;
  localparam logic [1:0] RES_ILLEGAL   = 2'b11;

  typedef enum logic [1:0] {
    SILENCE = 2'd0,
    ONSET   = 2'd1,
    SPEECH  = 2'd2,
    HANG    = 2'd3
  } vad_state_t;

  // Only a definite speech/non-speech code advances the smoother.
  function automatic logic is_decision(input logic [1:0] res);
    return (res == RES_SPEECH) || (res == RES_NONSPEECH);
  endfunction

endpackage

// File: rtl/vad_hangover.sv
// Frame-level VAD smoother: onset confirmation plus hangover, one frame per
// cycle, all outputs registered.
module vad_hangover
  import vad_pkg::*;
#(
  parameter int ONSET_FRAMES = 2,
  parameter int HANG_FRAMES  = 8,
  parameter int CNT_W        = 4,
  parameter int FCNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        result,
  output logic              vad_out,
  output logic              vad_valid,
  output logic [1:0]        state_o,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              err
);

  if (ONSET_FRAMES < 1 || ONSET_FRAMES > (1 << CNT_W) - 1) begin : g_bad_onset
    $fatal(1, "vad_hangover: ONSET_FRAMES out of range");
  end
  if (HANG_FRAMES < 0 || HANG_FRAMES > (1 << CNT_W) - 1) begin : g_bad_hang
    $fatal(1, "vad_hangover: HANG_FRAMES out of range");
  end

  localparam logic [CNT_W-1:0] ONSET_C   = CNT_W'(ONSET_FRAMES);
  // Unused when HANG_FRAMES is 0: SPEECH then falls straight to SILENCE.
  localparam logic [CNT_W-1:0] HANG_LOAD = CNT_W'(HANG_FRAMES - 1);

  vad_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             is_speech;

  assign accept    = enable && is_decision(result);
  assign is_speech = (result == RES_SPEECH);
  assign state_o   = state;

  // vad_out is set alongside each state update so it reflects the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SILENCE;
      cnt       <= '0;
      vad_out   <= 1'b0;
      vad_valid <= 1'b0;
      err       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vad_valid <= accept;
      if (enable && result == RES_ILLEGAL) err <= 1'b1;
      if (accept) begin
        frame_cnt <= frame_cnt + FCNT_W'(1);
        case (state)
          SILENCE: begin
            if (is_speech) begin
              if (ONSET_FRAMES == 1) begin
                state   <= SPEECH;
                vad_out <= 1'b1;
              end else begin
                state   <= ONSET;
                cnt     <= CNT_W'(1);
                vad_out <= 1'b0;
              end
            end else begin
              vad_out <= 1'b0;
            end
          end
          ONSET: begin
            if (is_speech) begin
              if (cnt + CNT_W'(1) == ONSET_C) begin
                state   <= SPEECH;
                vad_out <= 1'b1;
              end else begin
                cnt     <= cnt + CNT_W'(1);
                vad_out <= 1'b0;
              end
            end else begin
              state   <= SILENCE;
              cnt     <= '0;
              vad_out <= 1'b0;
            end
          end
          SPEECH: begin
            if (is_speech) begin
              vad_out <= 1'b1;
            end else if (HANG_FRAMES == 0) begin
              state   <= SILENCE;
              vad_out <= 1'b0;
            end else begin
              state   <= HANG;
              cnt     <= HANG_LOAD;
              vad_out <= 1'b1;
            end
          end
          HANG: begin
            if (is_speech) begin
              state   <= SPEECH;
              vad_out <= 1'b1;
            end else if (cnt == '0) begin
              state   <= SILENCE;
              vad_out <= 1'b0;
            end else begin
              cnt     <= cnt - CNT_W'(1);
              vad_out <= 1'b1;
            end
          end
          default: begin
            state   <= SILENCE;
            cnt     <= '0;
            vad_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vad_hangover.sv
// Scoreboard bench for vad_hangover with ONSET_FRAMES=2, HANG_FRAMES=3, plus a
// narrow-counter instance for frame counter wrap.
module tb_vad_hangover;
  import vad_pkg::*;

  typedef struct packed {
    logic        vld;
    logic        out;
    logic [1:0]  st;
    logic [15:0] fc;
    logic        er;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [1:0]  result;
  logic        vad_out;
  logic        vad_valid;
  logic [1:0]  state_o;
  logic [15:0] frame_cnt;
  logic        err;

  logic        w_enable;
  logic [1:0]  w_result;
  logic        w_vad_out;
  logic        w_vad_valid;
  logic [1:0]  w_state_o;
  logic [3:0]  w_frame_cnt;
  logic        w_err;

  exp_t        sb[$];
  logic [15:0] exp_fc;
  int          n_cmp;
  int          n_bad;

  vad_hangover #(.ONSET_FRAMES(2), .HANG_FRAMES(3), .CNT_W(4), .FCNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .result(result),
    .vad_out(vad_out), .vad_valid(vad_valid), .state_o(state_o),
    .frame_cnt(frame_cnt), .err(err)
  );

  vad_hangover #(.ONSET_FRAMES(2), .HANG_FRAMES(3), .CNT_W(4), .FCNT_W(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .enable(w_enable), .result(w_result),
    .vad_out(w_vad_out), .vad_valid(w_vad_valid), .state_o(w_state_o),
    .frame_cnt(w_frame_cnt), .err(w_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push the expectation for this cycle, drive one cycle, sample 1 after the edge.
  task automatic step(input logic en, input logic [1:0] r, input logic e_vld,
                      input logic e_out, input logic [1:0] e_st, input logic e_err);
    exp_t e;
    if (e_vld) exp_fc = exp_fc + 16'd1;
    e.vld = e_vld;
    e.out = e_out;
    e.st  = e_st;
    e.fc  = exp_fc;
    e.er  = e_err;
    sb.push_back(e);
    enable = en;
    result = r;
    @(posedge clk);
    #1;
    enable = 1'b0;
    result = RES_NONE;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    exp_fc = 16'd0;
    n_cmp++;
    if ({vad_valid, vad_out, state_o, frame_cnt, err} !== {1'b0, 1'b0, SILENCE, 16'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset: got vld=%b out=%b st=%0d fc=%0d err=%b, want all zero",
               vad_valid, vad_out, state_o, frame_cnt, err);
    end
  endtask

  task automatic test_alternate();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) step(1'b1, RES_SPEECH,    1'b1, 1'b0, ONSET,   1'b0);
      else            step(1'b1, RES_NONSPEECH, 1'b1, 1'b0, SILENCE, 1'b0);
      e = sb.pop_front();
      n_cmp++;
      if ({vad_valid, vad_out, state_o, frame_cnt, err} !== {e.vld, e.out, e.st, e.fc, e.er}) begin
        n_bad++;
        $display("FAIL alternate[%0d]: got vld=%b out=%b st=%0d fc=%0d err=%b, want vld=%b out=%b st=%0d fc=%0d err=%b",
                 i, vad_valid, vad_out, state_o, frame_cnt, err, e.vld, e.out, e.st, e.fc, e.er);
      end
    end
  endtask

  task automatic test_onset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) step(1'b1, RES_SPEECH, 1'b1, 1'b0, ONSET,  1'b0);
      else        step(1'b1, RES_SPEECH, 1'b1, 1'b1, SPEECH, 1'b0);
      e = sb.pop_front();
      n_cmp++;
      if ({vad_valid, vad_out, state_o, frame_cnt, err} !== {e.vld, e.out, e.st, e.fc, e.er}) begin
        n_bad++;
        $display("FAIL onset[%0d]: got vld=%b out=%b st=%0d fc=%0d err=%b, want vld=%b out=%b st=%0d fc=%0d err=%b",
                 i, vad_valid, vad_out, state_o, frame_cnt, err, e.vld, e.out, e.st, e.fc, e.er);
      end
    end
  endtask

  task automatic test_hang();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) step(1'b1, RES_NONSPEECH, 1'b1, 1'b1, HANG,    1'b0);
      else       step(1'b1, RES_NONSPEECH, 1'b1, 1'b0, SILENCE, 1'b0);
      e = sb.pop_front();
      n_cmp++;
      if ({vad_valid, vad_out, state_o, frame_cnt, err} !== {e.vld, e.out, e.st, e.fc, e.er}) begin
        n_bad++;
        $display("FAIL hang[%0d]: got vld=%b out=%b st=%0d fc=%0d err=%b, want vld=%b out=%b st=%0d fc=%0d err=%b",
                 i, vad_valid, vad_out, state_o, frame_cnt, err, e.vld, e.out, e.st, e.fc, e.er);
      end
    end
  endtask

  task automatic test_bridge();
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0:       step(1'b1, RES_SPEECH,    1'b1, 1'b0, ONSET,   1'b0);
        1, 4:    step(1'b1, RES_SPEECH,    1'b1, 1'b1, SPEECH,  1'b0);
        8:       step(1'b1, RES_NONSPEECH, 1'b1, 1'b0, SILENCE, 1'b0);
        default: step(1'b1, RES_NONSPEECH, 1'b1, 1'b1, HANG,    1'b0);
      endcase
      e = sb.pop_front();
      n_cmp++;
      if ({vad_valid, vad_out, state_o, frame_cnt, err} !== {e.vld, e.out, e.st, e.fc, e.er}) begin
        n_bad++;
        $display("FAIL bridge[%0d]: got vld=%b out=%b st=%0d fc=%0d err=%b, want vld=%b out=%b st=%0d fc=%0d err=%b",
                 i, vad_valid, vad_out, state_o, frame_cnt, err, e.vld, e.out, e.st, e.fc, e.er);
      end
    end
  endtask

  task automatic test_ignored();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: step(1'b1, RES_ILLEGAL,   1'b0, 1'b0, SILENCE, 1'b1);
        1: step(1'b1, RES_NONE,      1'b0, 1'b0, SILENCE, 1'b1);
        2: step(1'b0, RES_SPEECH,    1'b0, 1'b0, SILENCE, 1'b1);
        3: step(1'b1, RES_SPEECH,    1'b1, 1'b0, ONSET,   1'b1);
        4: step(1'b1, RES_SPEECH,    1'b1, 1'b1, SPEECH,  1'b1);
        5: step(1'b1, RES_NONE,      1'b0, 1'b1, SPEECH,  1'b1);
        6: step(1'b0, RES_NONSPEECH, 1'b0, 1'b1, SPEECH,  1'b1);
        default: step(1'b1, RES_NONSPEECH, 1'b1, 1'b1, HANG, 1'b1);
      endcase
      e = sb.pop_front();
      n_cmp++;
      if ({vad_valid, vad_out, state_o, frame_cnt, err} !== {e.vld, e.out, e.st, e.fc, e.er}) begin
        n_bad++;
        $display("FAIL ignored[%0d]: got vld=%b out=%b st=%0d fc=%0d err=%b, want vld=%b out=%b st=%0d fc=%0d err=%b",
                 i, vad_valid, vad_out, state_o, frame_cnt, err, e.vld, e.out, e.st, e.fc, e.er);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    rst_n  = 1'b0;
    enable = 1'b1;
    result = RES_SPEECH;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    enable = 1'b0;
    result = RES_NONE;
    exp_fc = 16'd0;
    n_cmp++;
    if ({vad_valid, vad_out, state_o, frame_cnt, err} !== {1'b0, 1'b0, SILENCE, 16'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid: got vld=%b out=%b st=%0d fc=%0d err=%b, want all zero",
               vad_valid, vad_out, state_o, frame_cnt, err);
    end
    step(1'b1, RES_SPEECH, 1'b1, 1'b0, ONSET, 1'b0);
    e = sb.pop_front();
    n_cmp++;
    if ({vad_valid, vad_out, state_o, frame_cnt, err} !== {e.vld, e.out, e.st, e.fc, e.er}) begin
      n_bad++;
      $display("FAIL after_reset: got vld=%b out=%b st=%0d fc=%0d err=%b, want vld=%b out=%b st=%0d fc=%0d err=%b",
               vad_valid, vad_out, state_o, frame_cnt, err, e.vld, e.out, e.st, e.fc, e.er);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] want;
    for (int i = 0; i < 17; i++) begin
      w_enable = 1'b1;
      w_result = RES_NONSPEECH;
      @(posedge clk);
      #1;
      want = 4'(i + 1);
      n_cmp++;
      if (w_frame_cnt !== want || w_vad_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL wrap[%0d]: got fc=%0d vld=%b, want fc=%0d vld=1", i, w_frame_cnt, w_vad_valid, want);
      end
    end
    w_enable = 1'b0;
    w_result = RES_NONE;
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    result   = RES_NONE;
    w_enable = 1'b0;
    w_result = RES_NONE;
    exp_fc   = 16'd0;
    n_cmp    = 0;
    n_bad    = 0;
    test_reset();
    test_alternate();
    test_onset();
    test_hang();
    test_bridge();
    test_ignored();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vad_hangover.md
# vad_hangover

Frame-level decision smoother on the output side of `compare`. It consumes the per-frame 2-bit class decision that `compare` emits whenever `enable` is high. It applies onset confirmation and hangover to produce a stable speech/non-speech flag, `vad_out`, which drives the VAD system output. Its purpose is to suppress isolated false positives and to bridge short gaps inside speech.

## Interface
Parameters:
- `ONSET_FRAMES`, default 2: consecutive speech frames required to enter speech. Legal range 1 to 2^CNT_W−1.
- `HANG_FRAMES`, default 8: non-speech frames still reported as speech after speech ends. Legal range 0 to 2^CNT_W−1.
- `CNT_W`, default 4: width of the onset/hang counter.
- `FCNT_W`, default 16: width of the accepted-frame counter.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `enable`  in  1  frame strobe; `result` is sampled when high. May be high on consecutive cycles.
- `result`  in  2  class code from `compare`:
  - 2'b01: non-speech.
  - 2'b10: speech. Ties are encoded as speech upstream.
  - 2'b00: no decision.
  - 2'b11: illegal.
- `vad_out`  out  1  smoothed decision; holds until the next accepted frame.
- `vad_valid`  out  1  one-cycle pulse per accepted frame.
- `state_o`  out  2  current FSM state.
- `frame_cnt`  out  FCNT_W  count of accepted frames; wraps modulo 2^FCNT_W.
- `err`  out  1  sticky flag set by an illegal code.

## Operation
- Frame acceptance:
  - A frame is accepted when `enable`=1 and `result` is 01 or 10.
  - `enable`=0: `result` is ignored.
  - `enable`=1 with 00: ignored; no pulse, no state change.
  - `enable`=1 with 11: ignored; sets `err`. `err` clears only on reset.
- FSM states: SILENCE=0, ONSET=1, SPEECH=2, HANG=3. Transitions happen only on accepted frames. `cnt` is CNT_W bits.
- SILENCE:
  - speech → SPEECH if ONSET_FRAMES==1; otherwise → ONSET with cnt=1.
  - non-speech → stay.
- ONSET:
  - speech → if cnt+1==ONSET_FRAMES go to SPEECH; else cnt+=1.
  - non-speech → SILENCE, cnt=0.
- SPEECH:
  - speech → stay.
  - non-speech → SILENCE if HANG_FRAMES==0; else → HANG with cnt=HANG_FRAMES−1.
- HANG:
  - speech → SPEECH.
  - non-speech → SILENCE if cnt==0; else cnt−=1.
- Decision: `vad_out` = 1 iff the next state is SPEECH or HANG.
  - Consequence: exactly HANG_FRAMES trailing non-speech frames report 1.
  - ONSET frames report 0.
- `frame_cnt` increments by 1 per accepted frame, wrapping from all-ones to 0.
- Parameter legality is checked at elaboration; out-of-range values are a fatal error.

## Timing
- Reset (`rst_n` low at a rising edge) applies the following values on that edge:
  - state = SILENCE, cnt = 0;
  - `vad_out` = 0, `vad_valid` = 0, `err` = 0, `frame_cnt` = 0.
- Reset mid-operation takes priority over a simultaneous `enable`; that frame is dropped.
- Latency is 1 cycle. For a frame accepted at edge N, the following hold from edge N through N+1:
  - `vad_valid`=1;
  - `vad_out`, `state_o` and `frame_cnt` show the updated values.
- Throughput is one frame per cycle, with no backpressure. Back-to-back accepted frames hold `vad_valid` high continuously.
- Ignored frames hold all outputs except `vad_valid`, which is 0, and `err`.
- All outputs are registered; none has a combinational path from an input.

## Structure
- Shared package `vad_pkg` holds:
  - result codes RES_NONE, RES_NONSPEECH, RES_SPEECH, RES_ILLEGAL;
  - FSM state typedef/encoding `vad_state_t`, so `compare` and the bench share the encodings.
- Single flat module with no sub-module. The counters are small enough to stay inline.

## Test plan
Defaults used throughout: ONSET_FRAMES=2, HANG_FRAMES=3.

1. After reset, alternate speech, non-speech, speech, non-speech, one frame per cycle.
   - `vad_valid` is high on 4 cycles.
   - `vad_out` stays 0; state sequence is ONSET, SILENCE, ONSET, SILENCE; `frame_cnt`=4.
2. Two consecutive speech frames from SILENCE.
   - `vad_out` reads 0 then 1; state is SPEECH.
   - A third speech frame keeps `vad_out`=1.
3. From SPEECH, four non-speech frames.
   - `vad_out` reads 1,1,1,0; state is HANG, HANG, HANG, SILENCE.
4. From SPEECH, two non-speech frames, one speech frame, then four non-speech frames.
   - `vad_out` stays 1 through the first two non-speech frames and the speech frame, which returns state to SPEECH.
   - During the four non-speech frames `vad_out` reads 1,1,1,0, showing the hang counter reloads.
5. Invalid and ignored inputs:
   - `enable`=1 with 11: no pulse, `err`=1, and `err` stays set after later valid frames.
   - `enable`=1 with 00: no pulse.
   - `enable`=0 with 10: no effect.
6. Reset and wrap:
   - Drive `rst_n` low for one cycle while in HANG, coincident with `enable`=1 and speech. Next cycle: state SILENCE, `vad_out`=0, `err`=0, `frame_cnt`=0, no `vad_valid`.
   - Run with FCNT_W=4 for 17 frames: `frame_cnt` wraps to 1.
